// File: rtl/mem_arb_pkg.sv
// Shared constants and encodings for the memory port arbiter.
// Round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

   localparam int MEM_ADDR_W = 28;
   localparam int MEM_DATA_W = 128;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   typedef enum logic {
      SIDE_I = 1'b0,
      SIDE_D = 1'b1
   } side_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and slow-memory signals of the shared memory port.
// slave: arbiter view; master: requesters plus memory view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = mem_arb_pkg::MEM_ADDR_W,
   parameter int DATA_W = mem_arb_pkg::MEM_DATA_W
) ();

   logic              req_read_I;
   logic              req_write_I;
   logic [ADDR_W-1:0] req_addr_I;
   logic [DATA_W-1:0] req_wdata_I;
   logic [DATA_W-1:0] rdata_I;
   logic              ready_I;

   logic              req_read_D;
   logic              req_write_D;
   logic [ADDR_W-1:0] req_addr_D;
   logic [DATA_W-1:0] req_wdata_D;
   logic [DATA_W-1:0] rdata_D;
   logic              ready_D;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport slave (
      input  req_read_I, req_write_I, req_addr_I, req_wdata_I,
      input  req_read_D, req_write_D, req_addr_D, req_wdata_D,
      input  mem_rdata, mem_ready,
      output rdata_I, ready_I, rdata_D, ready_D,
      output mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output req_read_I, req_write_I, req_addr_I, req_wdata_I,
      output req_read_D, req_write_D, req_addr_D, req_wdata_D,
      output mem_rdata, mem_ready,
      input  rdata_I, ready_I, rdata_D, ready_D,
      input  mem_read, mem_write, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_port_arbiter_latch.sv
// Request latch: holds the granted command stable on the memory port.
// Loaded once per transaction in IDLE, cleared by reset.
module mem_req_latch #(
   parameter int ADDR_W = mem_arb_pkg::MEM_ADDR_W,
   parameter int DATA_W = mem_arb_pkg::MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              read_d,
   input  logic              write_d,
   input  logic [ADDR_W-1:0] addr_d,
   input  logic [DATA_W-1:0] wdata_d,
   output logic              read,
   output logic              write,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read  <= 1'b0;
         write <= 1'b0;
         addr  <= '0;
         wdata <= '0;
      end else if (load) begin
         read  <= read_d;
         write <= write_d;
         addr  <= addr_d;
         wdata <= wdata_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (I/D) arbiter for a single slow-memory line port.
// Fixed D priority by default; round-robin with MEM_ARB_RR_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input logic clk,
   input logic rst_n,
   mem_port_arbiter_if.slave bus
);

   state_t state;
   state_t state_nxt;
   side_t  grant;
   side_t  win;
   side_t  tie_side;

   logic pend_i;
   logic pend_d;
   logic load;
   logic done;

   logic              sel_rd;
   logic              sel_wr;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   logic              lat_rd;
   logic              lat_wr;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   logic [DATA_W-1:0] rdata_i_q;
   logic [DATA_W-1:0] rdata_d_q;

   assign pend_i = bus.req_read_I | bus.req_write_I;
   assign pend_d = bus.req_read_D | bus.req_write_D;
   assign load   = (state == IDLE) && (pend_i || pend_d);
   assign done   = (state == BUSY) && bus.mem_ready;

`ifdef MEM_ARB_RR_EN
   side_t last_grant;

   assign tie_side = side_t'(~last_grant);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= SIDE_I;
      else if (load)
         last_grant <= win;
   end
`else
   assign tie_side = SIDE_D;
`endif

   always_comb begin
      win = SIDE_D;
      unique case (1'b1)
         pend_i && pend_d:  win = tie_side;
         pend_d && !pend_i: win = SIDE_D;
         pend_i && !pend_d: win = SIDE_I;
         default:           win = SIDE_D;
      endcase
   end

   // A write wins over a simultaneous read from the same side
   always_comb begin
      sel_wr    = bus.req_write_I;
      sel_rd    = bus.req_read_I;
      sel_addr  = bus.req_addr_I;
      sel_wdata = bus.req_wdata_I;
      if (win == SIDE_D) begin
         sel_wr    = bus.req_write_D;
         sel_rd    = bus.req_read_D;
         sel_addr  = bus.req_addr_D;
         sel_wdata = bus.req_wdata_D;
      end
   end

   mem_req_latch #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_latch (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .read_d  (sel_rd & ~sel_wr),
      .write_d (sel_wr),
      .addr_d  (sel_addr),
      .wdata_d (sel_wdata),
      .read    (lat_rd),
      .write   (lat_wr),
      .addr    (lat_addr),
      .wdata   (lat_wdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (pend_i || pend_d) state_nxt = BUSY;
         BUSY:    if (bus.mem_ready) state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         grant <= SIDE_D;
      else if (load)
         grant <= win;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_i_q <= '0;
         rdata_d_q <= '0;
      end else if (done) begin
         if (grant == SIDE_I)
            rdata_i_q <= bus.mem_rdata;
         else
            rdata_d_q <= bus.mem_rdata;
      end
   end

   assign bus.mem_addr  = lat_addr;
   assign bus.mem_wdata = lat_wdata;

   always_comb begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.ready_I   = 1'b0;
      bus.ready_D   = 1'b0;
      bus.rdata_I   = rdata_i_q;
      bus.rdata_D   = rdata_d_q;
      if (state == BUSY) begin
         bus.mem_read  = lat_rd;
         bus.mem_write = lat_wr;
      end
      // Memory data passes straight through on the completion cycle
      if (done) begin
         if (grant == SIDE_I) begin
            bus.ready_I = 1'b1;
            bus.rdata_I = bus.mem_rdata;
         end else begin
            bus.ready_D = 1'b1;
            bus.rdata_D = bus.mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a fixed-latency memory.
// Arbitration order is predicted from MEM_ARB_RR_EN.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int LAT = 3;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      bit           side;
      bit           wr;
      logic [27:0]  addr;
      logic [127:0] wdata;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();

   mem_port_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   txn_t         sb[$];
   int           n_chk = 0;
   int           n_fail = 0;
   bit           model_last = 1'b0;
   logic [127:0] exp_rd [2];

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] rd_pat(input logic [27:0] a);
      return {4{4'h5, a}} ^ 128'h0f0f_0000_3c3c_0000_9999_0000_1234_0000;
   endfunction

   task automatic drive(input bit side, input bit rd, input bit wr,
                        input logic [27:0] a, input logic [127:0] wd);
      if (side) begin
         bus.req_read_D  = rd;
         bus.req_write_D = wr;
         bus.req_addr_D  = a;
         bus.req_wdata_D = wd;
      end else begin
         bus.req_read_I  = rd;
         bus.req_write_I = wr;
         bus.req_addr_I  = a;
         bus.req_wdata_I = wd;
      end
   endtask

   task automatic drop(input bit side);
      if (side) begin
         bus.req_read_D  = 1'b0;
         bus.req_write_D = 1'b0;
      end else begin
         bus.req_read_I  = 1'b0;
         bus.req_write_I = 1'b0;
      end
   endtask

   task automatic push(input bit side, input bit wr,
                       input logic [27:0] a, input logic [127:0] wd);
      txn_t t;
      t.side = side;
      t.wr = wr;
      t.addr = a;
      t.wdata = wd;
      sb.push_back(t);
      model_last = side;
   endtask

   // Models the memory: waits for a command, checks it, holds, completes
   task automatic serve(input bit perturb, input int exp_lat);
      txn_t e;
      int n;
      logic rdy_w, rdy_l;
      logic [127:0] rd_w, rd_l;
      n = 0;
      while (!(bus.mem_read || bus.mem_write) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20 || sb.size() == 0) begin
         chk("cmd_timeout", 128'(n), 128'(exp_lat));
         return;
      end
      e = sb.pop_front();
      chk("arb_latency", 128'(n), 128'(exp_lat));
      chk("mem_addr", 128'(bus.mem_addr), 128'(e.addr));
      chk("mem_write", 128'(bus.mem_write), 128'(e.wr));
      chk("mem_read", 128'(bus.mem_read), 128'(!e.wr));
      if (e.wr) chk("mem_wdata", bus.mem_wdata, e.wdata);
      for (int i = 0; i < LAT; i++) begin
         if (perturb) begin
            if (e.side) bus.req_addr_D = ~e.addr;
            else bus.req_addr_I = ~e.addr;
         end
         @(negedge clk);
         chk("addr_hold", 128'(bus.mem_addr), 128'(e.addr));
         chk("cmd_hold", 128'({bus.mem_read, bus.mem_write}),
             128'({!e.wr, e.wr}));
      end
      bus.mem_rdata = rd_pat(e.addr);
      bus.mem_ready = 1'b1;
      exp_rd[e.side] = rd_pat(e.addr);
      #1;
      rdy_w = e.side ? bus.ready_D : bus.ready_I;
      rdy_l = e.side ? bus.ready_I : bus.ready_D;
      rd_w  = e.side ? bus.rdata_D : bus.rdata_I;
      rd_l  = e.side ? bus.rdata_I : bus.rdata_D;
      chk("ready_winner", 128'(rdy_w), 128'(1));
      chk("ready_loser", 128'(rdy_l), 128'(0));
      chk("rdata_pass", rd_w, exp_rd[e.side]);
      chk("rdata_loser", rd_l, exp_rd[!e.side]);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      drop(e.side);
      chk("release_gap", 128'({bus.mem_read, bus.mem_write}), 128'(0));
      chk("ready_pulse", 128'({bus.ready_I, bus.ready_D}), 128'(0));
      chk("rdata_held", e.side ? bus.rdata_D : bus.rdata_I, exp_rd[e.side]);
   endtask

   task automatic tie(input logic [27:0] ai, input logic [27:0] ad);
      bit w;
      w = RR ? !model_last : 1'b1;
      drive(1'b0, 1'b1, 1'b0, ai, '0);
      drive(1'b1, 1'b1, 1'b0, ad, '0);
      push(w, 1'b0, w ? ad : ai, '0);
      push(!w, 1'b0, w ? ai : ad, '0);
      serve(1'b0, 1);
      serve(1'b0, 2);
   endtask

   initial begin
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      bus.mem_rdata = '0;
      bus.mem_ready = 1'b0;

      #2 rst_n = 1'b0;
      #48;
      chk("rst_mem_cmd", 128'({bus.mem_read, bus.mem_write}), 128'(0));
      chk("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
      chk("rst_mem_wdata", bus.mem_wdata, 128'(0));
      chk("rst_ready", 128'({bus.ready_I, bus.ready_D}), 128'(0));
      chk("rst_rdata_I", bus.rdata_I, 128'(0));
      chk("rst_rdata_D", bus.rdata_D, 128'(0));
      chk("rst_state", 128'(dut.state), 128'(IDLE));
      #37 rst_n = 1'b1;
      @(negedge clk);

      drive(1'b0, 1'b1, 1'b0, 28'h0000010, '0);
      push(1'b0, 1'b0, 28'h0000010, '0);
      serve(1'b0, 1);

      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 28'h0000020, {16{8'hA5}});
      push(1'b1, 1'b1, 28'h0000020, {16{8'hA5}});
      serve(1'b0, 1);

      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tie(28'h0000100 + 28'(k), 28'h0000200 + 28'(k));
      end

      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 28'h0000300, '0);
      push(1'b0, 1'b0, 28'h0000300, '0);
      serve(1'b0, 1);
      @(negedge clk);
      tie(28'h0000310, 28'h0000320);

      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 28'h0000030, '0);
      push(1'b1, 1'b0, 28'h0000030, '0);
      serve(1'b1, 1);

      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 28'h0000040, {4{32'hDEAD_BEEF}});
      push(1'b0, 1'b1, 28'h0000040, {4{32'hDEAD_BEEF}});
      serve(1'b0, 1);

      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 28'h0000050, '0);
      @(negedge clk);
      chk("busy_read", 128'(bus.mem_read), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("async_drop", 128'({bus.mem_read, bus.mem_write}), 128'(0));
      chk("abort_rdata", bus.rdata_I | bus.rdata_D, 128'(0));
      bus.mem_ready = 1'b1;
      #1;
      chk("abort_ready", 128'({bus.ready_I, bus.ready_D}), 128'(0));
      drop(1'b0);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      rst_n = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      model_last = 1'b0;

      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 28'h0000060, '0);
      push(1'b0, 1'b0, 28'h0000060, '0);
      serve(1'b0, 1);

      chk("sb_drained", 128'(sb.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
